pattern_scan_accum: RTL and testbench

- Parametrised successor to the fixed 8-bit/8-entry/4-bit input-pattern scanner: captures an input word, walks a DEPTH-entry pattern table through a MAR-style address counter, and builds a result word from matching entries.
- Adds a run-time-writable table, a first-match mode, a BUSY/DONE handshake and a hit counter.
- Sits between the input pad register stage and the output pad register stage of the benchmark datapath.

---
 rtl/pattern_scan_accum_if.sv | 38 +++
 rtl/pattern_scan_accum.sv | 155 +++++++++++++++
 tb/tb_pattern_scan_accum.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_accum_if.sv
// Handshake and table-load bundle for pattern_scan_accum.
//   master : drives START, I, MODE and the table write port
//            (TBL_WE/TBL_ADDR/TBL_PAT/TBL_MASK/TBL_VAL); observes O, BUSY,
//            DONE, HIT_CNT.
//   slave  : the scanner itself, mirror directions.
// Handshake: START is a level request. The slave raises BUSY while a scan is
// in flight, pulses DONE for exactly one cycle when O/HIT_CNT take their new
// value, and waits for START to drop before another scan can begin.
interface pattern_scan_accum_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              START;
  logic [DATA_W-1:0] I;
  logic              MODE;
  logic              TBL_WE;
  logic [AW-1:0]     TBL_ADDR;
  logic [DATA_W-1:0] TBL_PAT;
  logic [DATA_W-1:0] TBL_MASK;
  logic [OUT_W-1:0]  TBL_VAL;
  logic [OUT_W-1:0]  O;
  logic              BUSY;
  logic              DONE;
  logic [AW:0]       HIT_CNT;

  modport master (
    output START, I, MODE, TBL_WE, TBL_ADDR, TBL_PAT, TBL_MASK, TBL_VAL,
    input  O, BUSY, DONE, HIT_CNT
  );

  modport slave (
    input  START, I, MODE, TBL_WE, TBL_ADDR, TBL_PAT, TBL_MASK, TBL_VAL,
    output O, BUSY, DONE, HIT_CNT
  );
endinterface

// File: rtl/pattern_scan_accum.sv
// Pattern scanner / accumulator.
// Captures input word I, walks a DEPTH-entry {PAT, MASK, VAL} table one entry
// per cycle through the MAR address counter and builds a result word from
// the entries whose masked pattern matches. MODE=0 ORs all hit values,
// MODE=1 stops at the first hit.
// Ports:
//   CLOCK     : single clock, rising edge
//   RESET_N   : synchronous active-low reset (clears table too)
//   bus       : pattern_scan_accum_if.slave (START/I/MODE, table write port,
//               O/BUSY/DONE/HIT_CNT)
//   dbg_state : current FSM state (0 IDLE, 1 INIT, 2 LOOP, 3 END)
module pattern_scan_accum #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  pattern_scan_accum_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_LOOP = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     mar_q, mar_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              mode_q, mode_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0]  o_q, o_d;
  logic [AW:0]       hit_cnt_q, hit_cnt_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] pat_q  [DEPTH];
  logic [DATA_W-1:0] pat_d  [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] mask_d [DEPTH];
  logic [OUT_W-1:0]  val_q  [DEPTH];
  logic [OUT_W-1:0]  val_d  [DEPTH];

  logic              busy;
  logic              hit;
  logic              addr_ok;
  logic [OUT_W-1:0]  out_nx;
  logic [AW:0]       cnt_nx;

  assign busy    = (state_q == S_INIT) || (state_q == S_LOOP);
  // Zero-extend so the range test stays meaningful when DEPTH is not 2**AW.
  assign addr_ok = ({1'b0, bus.TBL_ADDR} < (AW+1)'(DEPTH));
  assign hit     = (((in_q ^ pat_q[mar_q]) & mask_q[mar_q]) == '0);

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    in_d      = in_q;
    mode_d    = mode_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    hit_cnt_d = hit_cnt_q;
    done_d    = 1'b0;
    pat_d     = pat_q;
    mask_d    = mask_q;
    val_d     = val_q;
    out_nx    = out_q;
    cnt_nx    = cnt_q;

    // Table is frozen during a scan; an IDLE write lands before INIT reads it.
    if (bus.TBL_WE && !busy && addr_ok) begin
      pat_d[bus.TBL_ADDR]  = bus.TBL_PAT;
      mask_d[bus.TBL_ADDR] = bus.TBL_MASK;
      val_d[bus.TBL_ADDR]  = bus.TBL_VAL;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_INIT;
      end
      S_INIT: begin
        in_d    = bus.I;
        mode_d  = bus.MODE;
        out_d   = '0;
        cnt_d   = '0;
        mar_d   = '0;
        state_d = S_LOOP;
      end
      S_LOOP: begin
        if (hit) begin
          cnt_nx = cnt_q + (AW+1)'(1);
          out_nx = mode_q ? val_q[mar_q] : (out_q | val_q[mar_q]);
        end
        out_d = out_nx;
        cnt_d = cnt_nx;
        // The published result must include this cycle's hit, so O and
        // HIT_CNT take the next-values rather than the registered ones.
        if ((mode_q && hit) || (mar_q == LAST)) begin
          state_d   = S_END;
          o_d       = out_nx;
          hit_cnt_d = cnt_nx;
          done_d    = 1'b1;
        end else begin
          mar_d = mar_q + AW'(1);
        end
      end
      S_END: begin
        if (!bus.START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      mar_q     <= '0;
      in_q      <= '0;
      mode_q    <= 1'b0;
      out_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      hit_cnt_q <= '0;
      done_q    <= 1'b0;
      pat_q     <= '{default: '0};
      mask_q    <= '{default: '0};
      val_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      in_q      <= in_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      hit_cnt_q <= hit_cnt_d;
      done_q    <= done_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      val_q     <= val_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done_q;
  assign bus.HIT_CNT = hit_cnt_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_pattern_scan_accum.sv
module tb_pattern_scan_accum;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 4;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = OUT_W + AW + 1;

  // ---------------- clock / reset ----------------
  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] dbg_state;

  always #5 CLOCK = ~CLOCK;

  pattern_scan_accum_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  pattern_scan_accum #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  logic [DATA_W-1:0] m_pat  [DEPTH];
  logic [DATA_W-1:0] m_mask [DEPTH];
  logic [OUT_W-1:0]  m_val  [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int e = 0; e < DEPTH; e++) begin
      m_pat[e] = '0; m_mask[e] = '0; m_val[e] = '0;
    end
  endfunction

  function automatic void model_scan(input logic [DATA_W-1:0] i, input bit mode,
                                     output logic [OUT_W-1:0] o, output logic [AW:0] cnt,
                                     output int lat);
    o = '0; cnt = '0; lat = DEPTH + 1;
    for (int e = 0; e < DEPTH; e++) begin
      if (((i ^ m_pat[e]) & m_mask[e]) == '0) begin
        cnt = cnt + 1'b1;
        if (mode) begin
          o = m_val[e];
          lat = e + 2;
          break;
        end
        o = o | m_val[e];
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic tbl_write(input int a, input logic [DATA_W-1:0] p,
                           input logic [DATA_W-1:0] m, input logic [OUT_W-1:0] v);
    bus.TBL_ADDR = AW'(a); bus.TBL_PAT = p; bus.TBL_MASK = m; bus.TBL_VAL = v;
    bus.TBL_WE = 1'b1;
    tick();
    bus.TBL_WE = 1'b0;
    m_pat[a] = p; m_mask[a] = m; m_val[a] = v;
  endtask

  // Starts a scan and waits for DONE. Edge 0 is the edge that samples START.
  // poke_at >= 0 raises a (to-be-ignored) write of entry 7 during the scan.
  // Any TBL_WE already set by the caller is held through edge 0 only.
  task automatic run_scan(input logic [DATA_W-1:0] i, input bit mode,
                          input int poke_at, input bit hold_start);
    logic [OUT_W-1:0] eo;
    logic [AW:0]      ec;
    logic [W-1:0]     e;
    int               lat;
    int               busy_n;
    bit               got;
    model_scan(i, mode, eo, ec, lat);
    exp_q.push_back({ec, eo});
    bus.I = i; bus.MODE = mode; bus.START = 1'b1;
    busy_n = 0; got = 1'b0;
    for (int n = 0; n < DEPTH + 8; n++) begin
      @(posedge CLOCK); #1;
      if (n == 0) bus.TBL_WE = 1'b0;
      if (n == poke_at) begin
        bus.TBL_ADDR = AW'(7); bus.TBL_PAT = '0; bus.TBL_MASK = '0;
        bus.TBL_VAL = '1; bus.TBL_WE = 1'b1;
      end else if (n == poke_at + 1) begin
        bus.TBL_WE = 1'b0;
      end
      if (bus.BUSY) busy_n++;
      if (bus.DONE) begin
        got = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("o", bus.O, e[OUT_W-1:0]);
          check_eq("hit_cnt", bus.HIT_CNT, e[W-1:OUT_W]);
          check_eq("done_latency", n, lat);
          check_eq("busy_cycles", busy_n, lat);
        end
        break;
      end
    end
    if (!got) check_eq("done_timeout", 0, 1);
    bus.TBL_WE = 1'b0;
    if (!hold_start) begin
      bus.START = 1'b0;
      tick();
      check_eq("back_to_idle", dbg_state, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [OUT_W-1:0]  o_hold;
    logic [DATA_W-1:0] ri;
    bit                done_seen;

    bus.START = 0; bus.I = '0; bus.MODE = 0; bus.TBL_WE = 0;
    bus.TBL_ADDR = '0; bus.TBL_PAT = '0; bus.TBL_MASK = '0; bus.TBL_VAL = '0;
    model_clear();
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    check_eq("rst_o", bus.O, 0);
    check_eq("rst_hit_cnt", bus.HIT_CNT, 0);
    check_eq("rst_done", bus.DONE, 0);
    check_eq("rst_busy", bus.BUSY, 0);
    check_eq("rst_state", dbg_state, 0);

    // 1: zero table, every entry hits with VAL 0.
    run_scan(8'hA5, 1'b0, -1, 1'b0);

    // 2: two matching entries, the rest never match A5.
    for (int e = 0; e < DEPTH; e++) tbl_write(e, 8'h00, 8'hFF, 4'h0);
    tbl_write(2, 8'hA0, 8'hF0, 4'h1);
    tbl_write(5, 8'h05, 8'h0F, 4'h8);
    run_scan(8'hA5, 1'b0, -1, 1'b0);

    // 3 + 4: first-hit mode, then hold START in END.
    run_scan(8'hA5, 1'b1, -1, 1'b1);
    o_hold = bus.O;
    done_seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus.DONE) done_seen = 1'b1;
      check_eq("hold_o", bus.O, o_hold);
      check_eq("hold_state", dbg_state, 3);
    end
    check_eq("hold_no_done", done_seen, 0);
    bus.START = 1'b0;
    tick();
    run_scan(8'h00, 1'b1, -1, 1'b0);

    // 5: write during LOOP must be ignored (model left unchanged).
    run_scan(8'hA5, 1'b0, 3, 1'b0);
    run_scan(8'hA5, 1'b0, -1, 1'b0);

    // 6: reset mid-scan while MAR=4 (after edge 5).
    bus.I = 8'hA5; bus.MODE = 1'b0; bus.START = 1'b1;
    done_seen = 1'b0;
    for (int n = 0; n < 7; n++) begin
      tick();
      if (bus.DONE) done_seen = 1'b1;
      if (n == 5) begin
        check_eq("pre_rst_busy", bus.BUSY, 1);
        RESET_N = 1'b0; bus.START = 1'b0;
      end else if (n == 6) begin
        RESET_N = 1'b1;
        check_eq("abort_state", dbg_state, 0);
        check_eq("abort_o", bus.O, 0);
        check_eq("abort_hit_cnt", bus.HIT_CNT, 0);
        check_eq("abort_busy", bus.BUSY, 0);
      end
    end
    check_eq("abort_no_done", done_seen, 0);
    model_clear();
    run_scan(8'hA5, 1'b0, -1, 1'b0);

    // Random tables, including a write coincident with START in IDLE.
    for (int r = 0; r < 6; r++) begin
      ri = DATA_W'($urandom_range(0, 255));
      for (int k = 0; k < 3; k++)
        tbl_write($urandom_range(0, DEPTH - 1), ri ^ DATA_W'($urandom_range(0, 3)),
                  DATA_W'($urandom_range(0, 255)), OUT_W'($urandom_range(0, 15)));
      bus.TBL_ADDR = AW'($urandom_range(0, DEPTH - 1));
      bus.TBL_PAT  = ri;
      bus.TBL_MASK = DATA_W'($urandom_range(0, 255));
      bus.TBL_VAL  = OUT_W'($urandom_range(1, 15));
      bus.TBL_WE   = 1'b1;
      m_pat[bus.TBL_ADDR] = bus.TBL_PAT;
      m_mask[bus.TBL_ADDR] = bus.TBL_MASK;
      m_val[bus.TBL_ADDR] = bus.TBL_VAL;
      run_scan(ri, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
